// File: rtl/conv_pkg.sv
// Shared state, command and acknowledge encodings for the convolution layer
// sequencer and the input interface that answers its commands.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_LOAD    = 3'd3,
        ST_OUT     = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CMD_IDLE    = 2'd0,
        CMD_PRELOAD = 2'd1,
        CMD_SHIFT   = 2'd2,
        CMD_LOAD    = 2'd3
    } in_cmd_e;

    typedef enum logic [1:0] {
        ACK_IDLE        = 2'd0,
        ACK_PRELOAD_FIN = 2'd1,
        ACK_SHIFT_FIN   = 2'd2,
        ACK_LOAD_FIN    = 2'd3
    } in_ack_e;

    // Counter width for n steps; a single-step counter still gets one bit.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_step_counter.sv
// Step counter over 0..MAX-1: clear wins over increment, and an increment
// on the last value wraps to zero.
module conv_step_counter
    import conv_pkg::*;
#(
    parameter  int MAX = 4,
    localparam int W   = ctr_width(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         last_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign last_o  = (count_q == W'(MAX - 1));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = last_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Walks an image through preload / shift / load / output passes, issuing a
// one-cycle command on each state entry and waiting on the matching ack.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter  int NUM_WEIGHT = 4,
    parameter  int NUM_SHIFT  = 6,
    parameter  int NUM_BLOCK  = 1,
    localparam int WW = ctr_width(NUM_WEIGHT),
    localparam int SW = ctr_width(NUM_SHIFT),
    localparam int BW = ctr_width(NUM_BLOCK)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [1:0]    in_ack_i,
    input  logic          out_ready_i,
    output logic [1:0]    in_cmd_o,
    output logic [2:0]    state_o,
    output logic [WW-1:0] weight_idx_o,
    output logic [SW-1:0] shift_idx_o,
    output logic [BW-1:0] block_idx_o,
    output logic          out_valid_o,
    output logic          busy_o,
    output logic          done_o
);

    state_e  state_q, state_d;
    in_cmd_e inCmd_q, inCmd_d;
    logic    weightInc, shiftInc, blockInc, clrAll;
    logic    weightLast, shiftLast, blockLast;

    conv_step_counter #(.MAX(NUM_WEIGHT)) u_weight (
        .clk(clk), .rst_n(rst_n), .inc_i(weightInc), .clr_i(clrAll),
        .count_o(weight_idx_o), .last_o(weightLast)
    );

    conv_step_counter #(.MAX(NUM_SHIFT)) u_shift (
        .clk(clk), .rst_n(rst_n), .inc_i(shiftInc), .clr_i(clrAll),
        .count_o(shift_idx_o), .last_o(shiftLast)
    );

    conv_step_counter #(.MAX(NUM_BLOCK)) u_block (
        .clk(clk), .rst_n(rst_n), .inc_i(blockInc), .clr_i(clrAll),
        .count_o(block_idx_o), .last_o(blockLast)
    );

    // Abort overrides everything; otherwise every transition also needs enable.
    always_comb begin
        state_d   = state_q;
        inCmd_d   = CMD_IDLE;
        weightInc = 1'b0;
        shiftInc  = 1'b0;
        blockInc  = 1'b0;
        clrAll    = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
            clrAll  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i && start_i) begin
                        state_d = ST_PRELOAD;
                        inCmd_d = CMD_PRELOAD;
                        clrAll  = 1'b1;
                    end
                end
                ST_PRELOAD: begin
                    if (enable_i && in_ack_i == ACK_PRELOAD_FIN) begin
                        state_d = ST_SHIFT;
                        inCmd_d = CMD_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (enable_i && in_ack_i == ACK_SHIFT_FIN) begin
                        weightInc = 1'b1;
                        if (weightLast) begin
                            state_d = ST_OUT;
                        end else begin
                            inCmd_d = CMD_SHIFT;
                        end
                    end
                end
                ST_LOAD: begin
                    if (enable_i && in_ack_i == ACK_LOAD_FIN) begin
                        state_d = ST_SHIFT;
                        inCmd_d = CMD_SHIFT;
                    end
                end
                ST_OUT: begin
                    if (enable_i && out_ready_i) begin
                        if (!shiftLast) begin
                            shiftInc = 1'b1;
                            state_d  = ST_LOAD;
                            inCmd_d  = CMD_LOAD;
                        end else if (!blockLast) begin
                            shiftInc = 1'b1;
                            blockInc = 1'b1;
                            state_d  = ST_PRELOAD;
                            inCmd_d  = CMD_PRELOAD;
                        end else begin
                            clrAll  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (enable_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    clrAll  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            inCmd_q <= CMD_IDLE;
        end else begin
            state_q <= state_d;
            inCmd_q <= inCmd_d;
        end
    end

    assign in_cmd_o    = inCmd_q;
    assign state_o     = state_q;
    assign out_valid_o = (state_q == ST_OUT);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboarded bench: a default sequencer plus a 2-block/2-shift/1-weight one,
// driven by an ack responder that answers whichever state the selected DUT is in.
module tb_conv_layer_sequencer;
    import conv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, st, ab, ordy, selB;
    logic [1:0] ack;

    logic [1:0] cmdA, cmdB;
    logic [2:0] stateA, stateB;
    logic [1:0] wA;
    logic [2:0] sA;
    logic [0:0] bA, wB, sB, bB;
    logic       ovA, ovB, busyA, busyB, doneA, doneB;

    logic [1:0] obsCmd;
    logic [2:0] obsState;
    logic [1:0] obsWidx;
    logic [2:0] obsSidx;
    logic       obsBidx, obsOv, obsBusy, obsDone;

    assign obsCmd   = selB ? cmdB : cmdA;
    assign obsState = selB ? stateB : stateA;
    assign obsWidx  = selB ? {1'b0, wB} : wA;
    assign obsSidx  = selB ? {2'b00, sB} : sA;
    assign obsBidx  = selB ? bB[0] : bA[0];
    assign obsOv    = selB ? ovB : ovA;
    assign obsBusy  = selB ? busyB : busyA;
    assign obsDone  = selB ? doneB : doneA;

    conv_layer_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable_i(en), .start_i(st & ~selB), .abort_i(ab),
        .in_ack_i(selB ? 2'b00 : ack), .out_ready_i(ordy & ~selB),
        .in_cmd_o(cmdA), .state_o(stateA), .weight_idx_o(wA), .shift_idx_o(sA),
        .block_idx_o(bA), .out_valid_o(ovA), .busy_o(busyA), .done_o(doneA)
    );

    conv_layer_sequencer #(.NUM_WEIGHT(1), .NUM_SHIFT(2), .NUM_BLOCK(2)) dutB (
        .clk(clk), .rst_n(rst_n), .enable_i(en), .start_i(st & selB), .abort_i(ab),
        .in_ack_i(selB ? ack : 2'b00), .out_ready_i(ordy & selB),
        .in_cmd_o(cmdB), .state_o(stateB), .weight_idx_o(wB), .shift_idx_o(sB),
        .block_idx_o(bB), .out_valid_o(ovB), .busy_o(busyB), .done_o(doneB)
    );

    int checks = 0;
    int errors = 0;
    int nPreload, nShift, nLoad, nHandshake, nDone, cycle;
    bit readyHold, autoAck;
    logic [1:0] expQ[$];

    // One clock: score any command against the queue, then drive the responder.
    task automatic stepCycle();
        logic [1:0] expCmd;
        @(posedge clk);
        #1;
        cycle++;
        if (obsCmd != 2'd0) begin
            case (obsCmd)
                2'd1:    nPreload++;
                2'd2:    nShift++;
                default: nLoad++;
            endcase
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL cmd_order got=%0d exp=none (cycle %0d)", obsCmd, cycle);
            end else begin
                expCmd = expQ.pop_front();
                if (obsCmd !== expCmd) begin
                    errors++;
                    $display("[TB] FAIL cmd_order got=%0d exp=%0d (cycle %0d)", obsCmd, expCmd, cycle);
                end
            end
        end
        if (obsDone) nDone++;
        st  = 1'b0;
        ack = 2'd0;
        if (autoAck && (obsState == ST_PRELOAD || obsState == ST_SHIFT || obsState == ST_LOAD))
            ack = obsState[1:0];
        ordy = !readyHold;
        if (ordy && obsOv && en && !ab) nHandshake++;
    endtask

    function automatic void pushImage(input int nw, input int ns, input int nb);
        for (int b = 0; b < nb; b++) begin
            expQ.push_back(2'd1);
            for (int s = 0; s < ns; s++) begin
                if (s > 0) expQ.push_back(2'd3);
                for (int w = 0; w < nw; w++) expQ.push_back(2'd2);
            end
        end
    endfunction

    task automatic startImage(input int nw, input int ns, input int nb);
        nPreload = 0; nShift = 0; nLoad = 0; nHandshake = 0; nDone = 0; cycle = 0;
        expQ.delete();
        pushImage(nw, ns, nb);
        st = 1'b1;
    endtask

    task automatic waitState(input string tag, input logic [2:0] s, input int sIdx, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            stepCycle();
            hit = (obsState == s) && (sIdx < 0 || int'(obsSidx) == sIdx);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("[TB] FAIL %s_wait got=state%0d exp=state%0d within %0d cycles", tag, obsState, s, budget);
        end
    endtask

    // Runs the current image to done and scores totals against the handshake model.
    task automatic finishImage(input string tag, input int nw, input int ns, input int nb, input bit chkLat);
        int lat = -1;
        int expLat = nb * (1 + ns * (nw + 1) + (ns - 1)) + 1;
        for (int i = 0; i < 400 && lat < 0; i++) begin
            stepCycle();
            if (obsDone) lat = cycle;
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout got=no_done exp=done", tag);
        end
        if (chkLat) begin
            checks++;
            if (lat != expLat) begin errors++; $display("[TB] FAIL %s_latency got=%0d exp=%0d", tag, lat, expLat); end
        end
        checks++;
        if (nPreload != nb) begin errors++; $display("[TB] FAIL %s_preloads got=%0d exp=%0d", tag, nPreload, nb); end
        checks++;
        if (nShift != nw * ns * nb) begin errors++; $display("[TB] FAIL %s_shifts got=%0d exp=%0d", tag, nShift, nw * ns * nb); end
        checks++;
        if (nLoad != (ns - 1) * nb) begin errors++; $display("[TB] FAIL %s_loads got=%0d exp=%0d", tag, nLoad, (ns - 1) * nb); end
        checks++;
        if (nHandshake != ns * nb) begin errors++; $display("[TB] FAIL %s_handshakes got=%0d exp=%0d", tag, nHandshake, ns * nb); end
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL %s_pending got=%0d exp=0", tag, expQ.size()); end
        stepCycle();
        checks++;
        if (nDone !== 1 || obsBusy !== 1'b0 || obsDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_after got=done%0d/busy%0b/pulse%0b exp=1/0/0", tag, nDone, obsBusy, obsDone);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; st = 1'b0; ab = 1'b0; ack = 2'd0; ordy = 1'b1;
        selB = 1'b0; readyHold = 1'b0; autoAck = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({cmdA, stateA, wA, sA, bA, ovA, busyA, doneA} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_a got=%h exp=0", {cmdA, stateA, wA, sA, bA, ovA, busyA, doneA});
        end
        checks++;
        if ({cmdB, stateB, wB, sB, bB, ovB, busyB, doneB} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_b got=%h exp=0", {cmdB, stateB, wB, sB, bB, ovB, busyB, doneB});
        end
        rst_n = 1'b1;
        stepCycle();
    endtask

    task automatic test_full_image();
        startImage(4, 6, 1);
        finishImage("full", 4, 6, 1, 1'b1);
    endtask

    task automatic test_blocks();
        logic blkSeen[$];
        int lat = -1;
        selB = 1'b1;
        stepCycle();
        startImage(1, 2, 2);
        for (int i = 0; i < 100 && lat < 0; i++) begin
            stepCycle();
            if (obsCmd == 2'd1) blkSeen.push_back(obsBidx);
            if (obsDone) lat = cycle;
        end
        checks++;
        if (lat != 13) begin errors++; $display("[TB] FAIL blocks_latency got=%0d exp=13", lat); end
        checks++;
        if (blkSeen.size() != 2) begin
            errors++;
            $display("[TB] FAIL blocks_preloads got=%0d exp=2", blkSeen.size());
        end else begin
            checks++;
            if (blkSeen[0] !== 1'b0 || blkSeen[1] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL blocks_idx got=%0b,%0b exp=0,1", blkSeen[0], blkSeen[1]);
            end
        end
        checks++;
        if (expQ.size() != 0 || nLoad != 2) begin
            errors++;
            $display("[TB] FAIL blocks_seq got=pending%0d/loads%0d exp=0/2", expQ.size(), nLoad);
        end
        stepCycle();
        selB = 1'b0;
    endtask

    task automatic test_backpressure();
        readyHold = 1'b1;
        stepCycle();
        startImage(4, 6, 1);
        waitState("bp", ST_OUT, -1, 50);
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checks++;
            if (obsOv !== 1'b1 || obsState !== ST_OUT || obsCmd !== 2'd0) begin
                errors++;
                $display("[TB] FAIL bp_hold got=ov%0b/st%0d/cmd%0d exp=1/4/0", obsOv, obsState, obsCmd);
            end
        end
        readyHold = 1'b0;
        stepCycle();
        stepCycle();
        checks++;
        if (obsCmd !== 2'd3) begin errors++; $display("[TB] FAIL bp_release got=%0d exp=3", obsCmd); end
        finishImage("bp", 4, 6, 1, 1'b0);
    endtask

    task automatic test_misrouted();
        autoAck = 1'b0;
        stepCycle();
        startImage(4, 6, 1);
        stepCycle();
        ack = 2'd2;
        stepCycle();
        checks++;
        if (obsState !== ST_PRELOAD || obsCmd !== 2'd0) begin
            errors++;
            $display("[TB] FAIL misroute_preload got=st%0d/cmd%0d exp=1/0", obsState, obsCmd);
        end
        ack = 2'd1;
        stepCycle();
        ack = 2'd3;
        stepCycle();
        checks++;
        if (obsState !== ST_SHIFT || obsWidx !== 2'd0 || obsCmd !== 2'd0) begin
            errors++;
            $display("[TB] FAIL misroute_shift got=st%0d/w%0d/cmd%0d exp=2/0/0", obsState, obsWidx, obsCmd);
        end
        autoAck = 1'b1;
        ack = 2'd2;
        finishImage("misroute", 4, 6, 1, 1'b0);
    endtask

    task automatic test_enable_freeze();
        stepCycle();
        startImage(4, 6, 1);
        waitState("freeze", ST_SHIFT, -1, 20);
        stepCycle();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            ack = 2'd2;
            checks++;
            if (obsWidx !== 2'd1 || obsCmd !== 2'd0 || obsState !== ST_SHIFT) begin
                errors++;
                $display("[TB] FAIL freeze got=w%0d/cmd%0d/st%0d exp=1/0/2", obsWidx, obsCmd, obsState);
            end
        end
        en = 1'b1;
        finishImage("freeze", 4, 6, 1, 1'b0);
    endtask

    task automatic test_abort();
        stepCycle();
        startImage(4, 6, 1);
        waitState("abort", ST_LOAD, 3, 100);
        ab = 1'b1;
        stepCycle();
        checks++;
        if ({obsState, obsWidx, obsSidx, obsBidx, obsCmd, obsOv, obsDone} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL abort got=st%0d/w%0d/s%0d/b%0d/cmd%0d exp=0/0/0/0/0", obsState, obsWidx, obsSidx, obsBidx, obsCmd);
        end
        ab = 1'b0;
        expQ.delete();
        stepCycle();
        startImage(4, 6, 1);
        finishImage("post_abort", 4, 6, 1, 1'b1);
    endtask

    task automatic test_reset_mid();
        readyHold = 1'b1;
        stepCycle();
        startImage(4, 6, 1);
        waitState("rst", ST_OUT, -1, 50);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({obsState, obsWidx, obsSidx, obsBidx, obsCmd, obsOv, obsBusy} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid got=st%0d/w%0d/s%0d/ov%0b/busy%0b exp=0/0/0/0/0", obsState, obsWidx, obsSidx, obsOv, obsBusy);
        end
        readyHold = 1'b0;
        expQ.delete();
        stepCycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checks++;
            if (obsBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle got=%0b exp=0", obsBusy); end
        end
        startImage(4, 6, 1);
        finishImage("post_reset", 4, 6, 1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_full_image();
        test_blocks();
        test_backpressure();
        test_misrouted();
        test_enable_freeze();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
